// File: rtl/mempool_dma_chunker.sv
// Purpose : splits one whole-transfer DMA request into chunks that never cross
//           a ChunkBytes-aligned destination boundary, capping in-flight chunks.
// Latency : request accepted at T -> first chunk valid at T+1; one chunk/cycle.
// Backpr. : chunk fields hold while valid && !ready; valid drops only at the
//           outstanding cap and returns the cycle after done_i frees a slot.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   req_valid_i / req_ready_o         transfer request handshake (ready in IDLE)
//   req_src_i, req_dst_i              transfer source / destination byte address
//   req_num_bytes_i, req_id_i         transfer length and ID
//   chunk_valid_o / chunk_ready_i     chunk handshake towards the DMA backend
//   chunk_src_o, chunk_dst_o          chunk addresses
//   chunk_num_bytes_o, chunk_id_o     chunk length (1..ChunkBytes) and ID
//   chunk_last_o                      final chunk of the transfer
//   done_i                            backend finished one chunk (1-cycle pulse)
//   busy_o                            transfer in progress
//   trans_complete_o                  1-cycle pulse once the whole transfer is done
module mempool_dma_chunker #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned ChunkBytes     = 1024,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_src_i,
    input  logic [AddrWidth-1:0] req_dst_i,
    input  logic [31:0]          req_num_bytes_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 chunk_valid_o,
    input  logic                 chunk_ready_i,
    output logic [AddrWidth-1:0] chunk_src_o,
    output logic [AddrWidth-1:0] chunk_dst_o,
    output logic [31:0]          chunk_num_bytes_o,
    output logic [IdWidth-1:0]   chunk_id_o,
    output logic                 chunk_last_o,
    input  logic                 done_i,
    output logic                 busy_o,
    output logic                 trans_complete_o
);

    localparam int unsigned OffWidth = $clog2(ChunkBytes);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AddrWidth-1:0]  src_q, dst_q;
    logic [31:0]           remaining_q;
    logic [IdWidth-1:0]    id_q;
    logic [CntWidth-1:0]   outstanding_q;

    logic [31:0]           boundary_room;
    logic [31:0]           chunk_size;
    logic                  accept;
    logic                  issue;
    logic                  retire;

    // Bytes left before the destination crosses the next ChunkBytes boundary.
    assign boundary_room = 32'(ChunkBytes) - 32'(dst_q[OffWidth-1:0]);
    assign chunk_size    = (remaining_q < boundary_room) ? remaining_q : boundary_room;

    // A done_i with nothing outstanding (e.g. a stale completion after reset)
    // must not underflow the counter.
    assign retire = done_i && (outstanding_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        chunk_valid_o    = 1'b0;
        chunk_last_o     = 1'b0;
        trans_complete_o = 1'b0;
        accept           = 1'b0;
        issue            = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (req_valid_i) begin
                    state_d = (req_num_bytes_i != 32'd0) ? SPLIT : DRAIN;
                end
            end
            SPLIT: begin
                chunk_valid_o = (outstanding_q < CntWidth'(MaxOutstanding));
                chunk_last_o  = (chunk_size == remaining_q);
                issue         = chunk_valid_o && chunk_ready_i;
                if (issue && chunk_last_o) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Decided on the registered count, so completion lands the
                // cycle after the final done_i has been absorbed.
                if (outstanding_q == '0) begin
                    trans_complete_o = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q         <= '0;
            dst_q         <= '0;
            remaining_q   <= '0;
            id_q          <= '0;
            outstanding_q <= '0;
        end else begin
            if (accept) begin
                src_q       <= req_src_i;
                dst_q       <= req_dst_i;
                remaining_q <= req_num_bytes_i;
                id_q        <= req_id_i;
            end else if (issue) begin
                src_q       <= src_q + AddrWidth'(chunk_size);
                dst_q       <= dst_q + AddrWidth'(chunk_size);
                remaining_q <= remaining_q - chunk_size;
            end
            case ({issue, retire})
                2'b10:   outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01:   outstanding_q <= outstanding_q - CntWidth'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign chunk_src_o       = src_q;
    assign chunk_dst_o       = dst_q;
    assign chunk_num_bytes_o = chunk_size;
    assign chunk_id_o        = id_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_mempool_dma_chunker.sv
module tb_mempool_dma_chunker;

    localparam int unsigned CB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_src = '0;
    logic [31:0] req_dst = '0;
    logic [31:0] req_num_bytes = '0;
    logic [1:0]  req_id = '0;
    logic        chunk_valid;
    logic        chunk_ready = 1'b0;
    logic [31:0] chunk_src;
    logic [31:0] chunk_dst;
    logic [31:0] chunk_num_bytes;
    logic [1:0]  chunk_id;
    logic        chunk_last;
    logic        done = 1'b0;
    logic        busy;
    logic        trans_complete;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] nb;
        logic [1:0]  id;
        logic        last;
    } chunk_t;

    chunk_t exp_q[$];
    int     checks   = 0;
    int     errors   = 0;
    int     hs_count = 0;

    always #5 clk = ~clk;

    mempool_dma_chunker #(
        .AddrWidth(32), .IdWidth(2), .ChunkBytes(CB), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_src_i(req_src), .req_dst_i(req_dst),
        .req_num_bytes_i(req_num_bytes), .req_id_i(req_id),
        .chunk_valid_o(chunk_valid), .chunk_ready_i(chunk_ready),
        .chunk_src_o(chunk_src), .chunk_dst_o(chunk_dst),
        .chunk_num_bytes_o(chunk_num_bytes), .chunk_id_o(chunk_id),
        .chunk_last_o(chunk_last), .done_i(done),
        .busy_o(busy), .trans_complete_o(trans_complete)
    );

    // Scoreboard: every handshake pops the next expected chunk.
    always @(negedge clk) begin
        if (!rst && chunk_valid && chunk_ready) begin
            chunk_t obs;
            chunk_t expv;
            hs_count++;
            checks++;
            obs = '{src: chunk_src, dst: chunk_dst, nb: chunk_num_bytes,
                    id: chunk_id, last: chunk_last};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL chunk_unexpected got src=%h dst=%h nb=%0d id=%0d last=%0b required none",
                         obs.src, obs.dst, obs.nb, obs.id, obs.last);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL chunk got src=%h dst=%h nb=%0d id=%0d last=%0b required src=%h dst=%h nb=%0d id=%0d last=%0b",
                             obs.src, obs.dst, obs.nb, obs.id, obs.last,
                             expv.src, expv.dst, expv.nb, expv.id, expv.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent chunking model.
    function automatic void push_expected(input logic [31:0] s, input logic [31:0] d,
                                          input logic [31:0] n, input logic [1:0] id);
        logic [31:0] rem;
        logic [31:0] room;
        logic [31:0] sz;
        chunk_t      c;
        rem = n;
        while (rem != 0) begin
            room   = CB - (d % CB);
            sz     = (rem < room) ? rem : room;
            c.src  = s;
            c.dst  = d;
            c.nb   = sz;
            c.id   = id;
            c.last = (sz == rem);
            exp_q.push_back(c);
            s   = s + sz;
            d   = d + sz;
            rem = rem - sz;
        end
    endfunction

    // Drives one request; returns in the cycle after acceptance (T+1).
    task automatic send_req(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] n, input logic [1:0] id);
        int waited = 0;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_ready_timeout got 0 required 1");
        end
        push_expected(s, d, n, id);
        req_src = s; req_dst = d; req_num_bytes = n; req_id = id;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({req_ready, busy, chunk_valid, chunk_last, trans_complete} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 10000",
                     {req_ready, busy, chunk_valid, chunk_last, trans_complete});
        end
        checks++;
        if ({chunk_src, chunk_dst, chunk_num_bytes, chunk_id} !== 98'd0) begin
            errors++;
            $display("FAIL reset_fields got src=%h dst=%h nb=%0d id=%0d required 0",
                     chunk_src, chunk_dst, chunk_num_bytes, chunk_id);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_boundary_split();
        chunk_ready = 1'b1;
        send_req(32'h0000_1000, 32'h8000_0100, 32'd2000, 2'd1);
        checks++;
        if (chunk_valid !== 1'b1) begin
            errors++;
            $display("FAIL split_first_valid got %b required 1", chunk_valid);
        end
        tick();
        tick();
        // Two chunks in flight: cap reached, third waits for a done.
        checks++;
        if (chunk_valid !== 1'b0) begin
            errors++;
            $display("FAIL split_cap got %b required 0", chunk_valid);
        end
        pulse_done();
        tick();
        checks++;
        if (exp_q.size() != 0 || trans_complete !== 1'b0) begin
            errors++;
            $display("FAIL split_all_issued got left=%0d tc=%b required left=0 tc=0",
                     exp_q.size(), trans_complete);
        end
        done = 1'b1;
        tick();
        checks++;
        if (trans_complete !== 1'b0) begin
            errors++;
            $display("FAIL split_tc_early got %b required 0", trans_complete);
        end
        tick();
        done = 1'b0;
        checks++;
        if (trans_complete !== 1'b1) begin
            errors++;
            $display("FAIL split_tc got %b required 1", trans_complete);
        end
        tick();
        checks++;
        if ({trans_complete, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL split_idle got tc/ready/busy=%b required 010",
                     {trans_complete, req_ready, busy});
        end
    endtask

    task automatic test_outstanding_cap();
        int hs_before;
        chunk_ready = 1'b1;
        hs_before = hs_count;
        send_req(32'h0000_2000, 32'h0000_4000, 32'd4096, 2'd2);
        repeat (5) tick();
        checks++;
        if (hs_count - hs_before != 2 || chunk_valid !== 1'b0) begin
            errors++;
            $display("FAIL cap_hold got hs=%0d valid=%b required hs=2 valid=0",
                     hs_count - hs_before, chunk_valid);
        end
        pulse_done();
        checks++;
        if (chunk_valid !== 1'b1 || chunk_dst !== 32'h0000_4800) begin
            errors++;
            $display("FAIL cap_resume got valid=%b dst=%h required valid=1 dst=00004800",
                     chunk_valid, chunk_dst);
        end
        // Counter at 1: issue and done together must leave it at 1.
        pulse_done();
        checks++;
        if (chunk_valid !== 1'b1 || chunk_dst !== 32'h0000_4c00) begin
            errors++;
            $display("FAIL simul_issue_done got valid=%b dst=%h required valid=1 dst=00004c00",
                     chunk_valid, chunk_dst);
        end
        tick();
        checks++;
        if (chunk_valid !== 1'b0 || busy !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cap_drain got valid=%b busy=%b left=%0d required 0 1 0",
                     chunk_valid, busy, exp_q.size());
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        checks++;
        if (trans_complete !== 1'b1) begin
            errors++;
            $display("FAIL cap_tc got %b required 1", trans_complete);
        end
        tick();
    endtask

    task automatic test_zero_length();
        int hs_before;
        hs_before = hs_count;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy_before got %b required 0", busy);
        end
        send_req(32'h0000_0040, 32'h0000_0080, 32'd0, 2'd3);
        checks++;
        if ({trans_complete, busy, chunk_valid} !== 3'b110) begin
            errors++;
            $display("FAIL zero_t1 got tc/busy/valid=%b required 110",
                     {trans_complete, busy, chunk_valid});
        end
        tick();
        checks++;
        if ({trans_complete, busy, req_ready} !== 3'b001 || hs_count != hs_before) begin
            errors++;
            $display("FAIL zero_t2 got tc/busy/ready=%b hs=%0d required 001 hs=0",
                     {trans_complete, busy, req_ready}, hs_count - hs_before);
        end
    endtask

    task automatic test_backpressure();
        int hs_before;
        int bad = 0;
        chunk_ready = 1'b0;
        hs_before = hs_count;
        send_req(32'h3000_0010, 32'h5000_0020, 32'd100, 2'd1);
        for (int i = 0; i < 5; i++) begin
            if ({chunk_valid, chunk_src, chunk_dst, chunk_num_bytes, chunk_id, chunk_last} !==
                {1'b1, 32'h3000_0010, 32'h5000_0020, 32'd100, 2'd1, 1'b1}) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || hs_count != hs_before) begin
            errors++;
            $display("FAIL bp_stable got unstable_cycles=%0d hs=%0d required 0 0",
                     bad, hs_count - hs_before);
        end
        chunk_ready = 1'b1;
        tick();
        checks++;
        if (hs_count - hs_before != 1 || chunk_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake got hs=%0d valid=%b required 1 0",
                     hs_count - hs_before, chunk_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (trans_complete !== 1'b1) begin
            errors++;
            $display("FAIL bp_tc got %b required 1", trans_complete);
        end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        int tc_seen = 0;
        int waited  = 0;
        chunk_ready = 1'b1;
        send_req(32'h0000_0100, 32'h0000_0000, 32'd3072, 2'd2);
        tick();
        chunk_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, busy, chunk_valid, chunk_last, trans_complete} !== 5'b10000 ||
            {chunk_src, chunk_dst, chunk_num_bytes, chunk_id} !== 98'd0) begin
            errors++;
            $display("FAIL rst_async got ctrl=%b src=%h dst=%h nb=%0d required ctrl=10000 fields 0",
                     {req_ready, busy, chunk_valid, chunk_last, trans_complete},
                     chunk_src, chunk_dst, chunk_num_bytes);
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        pulse_done();
        for (int i = 0; i < 5; i++) begin
            if (trans_complete || busy) tc_seen++;
            tick();
        end
        checks++;
        if (tc_seen != 0) begin
            errors++;
            $display("FAIL rst_stale_done got active_cycles=%0d required 0", tc_seen);
        end
        // Fresh request that also wraps the destination past all-ones.
        chunk_ready = 1'b1;
        send_req(32'h0000_7000, 32'hFFFF_FF00, 32'd512, 2'd3);
        while (exp_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_new_req got left=%0d required 0", exp_q.size());
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        checks++;
        if (trans_complete !== 1'b1) begin
            errors++;
            $display("FAIL rst_new_tc got %b required 1", trans_complete);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_boundary_split();
        test_outstanding_cap();
        test_zero_length();
        test_backpressure();
        test_reset_mid_transfer();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
